tl_state_seq: RTL and testbench

TL_STATE_SEQ -- requirements
Module: tl_state_seq

---
 rtl/tl_state_seq.sv | 93 +++++++++
 tb/tb_tl_state_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tl_state_seq.sv
// Two-street traffic-light phase sequencer with optional protected left-turn phases.
// Dwell timing advances on tick; left-turn requests are latched until their left phase is served.
module tl_state_seq #(
    parameter int unsigned MIN_GRN  = 8,
    parameter int unsigned YEL_CYC  = 4,
    parameter int unsigned LEFT_CYC = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       La_req,
    input  logic       Lb_req,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A_GRN  = 3'b000,
        S_A_YEL  = 3'b001,
        S_A_LEFT = 3'b010,
        S_A_LYEL = 3'b011,
        S_B_GRN  = 3'b100,
        S_B_YEL  = 3'b101,
        S_B_LEFT = 3'b110,
        S_B_LYEL = 3'b111
    } state_e;

    localparam logic [3:0] GRN_LAST  = 4'(MIN_GRN - 1);
    localparam logic [3:0] YEL_LAST  = 4'(YEL_CYC - 1);
    localparam logic [3:0] LEFT_LAST = 4'(LEFT_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       la_pend_q, la_pend_d;
    logic       lb_pend_q, lb_pend_d;
    logic [3:0] dwell_last;
    logic       expired;

    // NOTE: every register updates with <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_A_GRN;
            timer_q   <= 4'd0;
            la_pend_q <= 1'b0;
            lb_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            la_pend_q <= la_pend_d;
            lb_pend_q <= lb_pend_d;
        end
    end

    always_comb begin
        // NOTE: every output is given a default first, so no path can infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        dwell_last = YEL_LAST;
        unique case (state_q)
            S_A_GRN, S_B_GRN:   dwell_last = GRN_LAST;
            S_A_LEFT, S_B_LEFT: dwell_last = LEFT_LAST;
            default:            dwell_last = YEL_LAST;
        endcase
        // Out-of-range timer values count as expiry, so the block can never stall.
        expired = (timer_q >= dwell_last);

        la_pend_d = (la_pend_q | La_req) & (state_q != S_A_LEFT);
        lb_pend_d = (lb_pend_q | Lb_req) & (state_q != S_B_LEFT);

        if (tick) begin
            unique case (state_q)
                S_A_GRN:  if (expired && !Ta) state_d = S_A_YEL;
                S_A_YEL:  if (expired) state_d = la_pend_q ? S_A_LEFT : S_B_GRN;
                S_A_LEFT: if (expired) state_d = S_A_LYEL;
                S_A_LYEL: if (expired) state_d = S_B_GRN;
                S_B_GRN:  if (expired && !Tb) state_d = S_B_YEL;
                S_B_YEL:  if (expired) state_d = lb_pend_q ? S_B_LEFT : S_A_GRN;
                S_B_LEFT: if (expired) state_d = S_B_LYEL;
                S_B_LYEL: if (expired) state_d = S_A_GRN;
            endcase
            // A held green with traffic present pins the timer at its last value.
            if (state_d != state_q) timer_d = 4'd0;
            else if (expired)       timer_d = dwell_last;
            else                    timer_d = timer_q + 4'd1;
        end
    end

    always_comb begin
        state = state_q;
    end

endmodule

// File: tb/tb_tl_state_seq.sv
// Self-checking bench for tl_state_seq: directed vector tables, tick-gating sequence,
// and randomized stimulus compared against a phase-level reference model.
module tb_tl_state_seq;

    localparam int MIN_GRN  = 8;
    localparam int YEL_CYC  = 4;
    localparam int LEFT_CYC = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       Ta = 1'b0;
    logic       Tb = 1'b0;
    logic       La_req = 1'b0;
    logic       Lb_req = 1'b0;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    tl_state_seq #(.MIN_GRN(MIN_GRN), .YEL_CYC(YEL_CYC), .LEFT_CYC(LEFT_CYC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .Ta     (Ta),
        .Tb     (Tb),
        .La_req (La_req),
        .Lb_req (Lb_req),
        .state  (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_n;
        bit         tk;
        bit         ta;
        bit         tb;
        bit         la;
        bit         lb;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(bit rst_n, bit tk, bit ta, bit tb, bit la, bit lb,
                                 logic [2:0] exp, int n);
        vec_t v;
        v.rst_n = rst_n; v.tk = tk; v.ta = ta; v.tb = tb; v.la = la; v.lb = lb; v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [2:0] act, logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst_n, bit tk, bit ta, bit tb, bit la, bit lb);
        reset_n = rst_n; tick = tk; Ta = ta; Tb = tb; La_req = la; Lb_req = lb;
        @(posedge clk);
        #1;
    endtask

    // Reference model: street (0=A, 1=B), stage within the street's cycle, ticks elapsed.
    int m_street, m_stage, m_el;
    bit m_pend[2];

    function automatic logic [2:0] model_state();
        return 3'(m_street * 4 + m_stage);
    endfunction

    function automatic void model_step(bit rst_n, bit tk, bit ta, bit tb, bit la, bit lb);
        int  dwell;
        bit  go;
        bit  np0, np1;
        bit  traffic;
        if (!rst_n) begin
            m_street = 0; m_stage = 0; m_el = 0; m_pend[0] = 0; m_pend[1] = 0;
            return;
        end
        np0 = (m_pend[0] | la) && !(m_street == 0 && m_stage == 2);
        np1 = (m_pend[1] | lb) && !(m_street == 1 && m_stage == 2);
        if (tk) begin
            dwell   = (m_stage == 0) ? MIN_GRN : (m_stage == 2) ? LEFT_CYC : YEL_CYC;
            traffic = (m_street == 0) ? ta : tb;
            go      = (m_el + 1 >= dwell) && (m_stage != 0 || !traffic);
            if (go) begin
                m_el = 0;
                case (m_stage)
                    0: m_stage = 1;
                    1: if (m_pend[m_street]) m_stage = 2;
                       else begin m_street = 1 - m_street; m_stage = 0; end
                    2: m_stage = 3;
                    default: begin m_street = 1 - m_street; m_stage = 0; end
                endcase
            end else begin
                m_el = (m_el + 1 > dwell - 1) ? dwell - 1 : m_el + 1;
            end
        end
        m_pend[0] = np0;
        m_pend[1] = np1;
    endfunction

    logic [2:0] seq[72];
    int         run0, run1, idx;
    logic [2:0] prev;
    bit         r, t, a, b, qa, qb;

    initial begin
        // Plain cycle, no requests: left phases skipped.
        push(0,1,0,0,0,0,3'b000,2);
        push(1,1,0,0,0,0,3'b000,7); push(1,1,0,0,0,0,3'b001,4);
        push(1,1,0,0,0,0,3'b100,8); push(1,1,0,0,0,0,3'b101,4);
        push(1,1,0,0,0,0,3'b000,1);
        // Ta held 30 cycles, then released.
        push(0,1,0,0,0,0,3'b000,1);
        push(1,1,1,0,0,0,3'b000,30);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b100,1);
        // Single A left request; next A cycle skips the left.
        push(0,1,0,0,0,0,3'b000,1);
        push(1,1,0,0,1,0,3'b000,1); push(1,1,0,0,0,0,3'b000,6);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b010,6);
        push(1,1,0,0,0,0,3'b011,4); push(1,1,0,0,0,0,3'b100,8);
        push(1,1,0,0,0,0,3'b101,4); push(1,1,0,0,0,0,3'b000,8);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b100,1);
        // Both requests together; Lb re-pulsed inside B left is dropped.
        push(0,1,0,0,0,0,3'b000,1);
        push(1,1,0,0,1,1,3'b000,1); push(1,1,0,0,0,0,3'b000,6);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b010,6);
        push(1,1,0,0,0,0,3'b011,4); push(1,1,0,0,0,0,3'b100,8);
        push(1,1,0,0,0,0,3'b101,4); push(1,1,0,0,0,0,3'b110,2);
        push(1,1,0,0,0,1,3'b110,1); push(1,1,0,0,0,0,3'b110,3);
        push(1,1,0,0,0,0,3'b111,4); push(1,1,0,0,0,0,3'b000,8);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b100,8);
        push(1,1,0,0,0,0,3'b101,4); push(1,1,0,0,0,0,3'b000,1);
        // Reset mid-left (timer=3) with a concurrent request: reset wins, pend cleared.
        push(0,1,0,0,0,0,3'b000,1);
        push(1,1,0,0,1,0,3'b000,1); push(1,1,0,0,0,0,3'b000,6);
        push(1,1,0,0,0,0,3'b001,4); push(1,1,0,0,0,0,3'b010,4);
        push(0,1,0,0,1,0,3'b000,1);
        push(1,1,0,0,0,0,3'b000,7); push(1,1,0,0,0,0,3'b001,4);
        push(1,1,0,0,0,0,3'b100,1);
        // Reset with tick low still clears.
        push(0,0,1,1,1,1,3'b000,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].tk, vecs[i].ta, vecs[i].tb, vecs[i].la, vecs[i].lb);
            check($sformatf("vec%0d", i), state, vecs[i].exp);
        end

        // tick every third cycle: dwell stretches 3x, state moves only after tick=1.
        drive(0,1,0,0,0,0);
        model_step(0,1,0,0,0,0);
        check("tick3_reset", state, 3'b000);
        prev = state;
        for (int k = 0; k < 72; k++) begin
            t = (k % 3 == 2);
            drive(1,t,0,0,0,0);
            model_step(1,t,0,0,0,0);
            check($sformatf("tick3_model%0d", k), state, model_state());
            if (!t) check($sformatf("tick3_hold%0d", k), state, prev);
            seq[k] = state;
            prev = state;
        end
        idx = 0;
        while (idx < 72 && seq[idx] == 3'b000) idx++;
        run0 = idx + 1;
        run1 = 0;
        while (idx < 72 && seq[idx] == 3'b001) begin idx++; run1++; end
        total++;
        if (run0 != 3 * MIN_GRN) begin
            bad++;
            $display("FAIL tick3_grn_len: got=%0d want=%0d", run0, 3 * MIN_GRN);
        end
        total++;
        if (run1 != 3 * YEL_CYC) begin
            bad++;
            $display("FAIL tick3_yel_len: got=%0d want=%0d", run1, 3 * YEL_CYC);
        end

        // Randomized run against the reference model.
        drive(0,1,0,0,0,0);
        model_step(0,1,0,0,0,0);
        check("rand_reset", state, model_state());
        a = 0; b = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 299) != 0);
            t  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) a = ~a;
            if ($urandom_range(0, 9) == 0) b = ~b;
            qa = ($urandom_range(0, 24) == 0);
            qb = ($urandom_range(0, 24) == 0);
            drive(r, t, a, b, qa, qb);
            model_step(r, t, a, b, qa, qb);
            check($sformatf("rand%0d", i), state, model_state());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
